motion_sequencer: RTL and testbench

- Sequences the actuator side of the self-driving car. It sits downstream of tesla_model_X.
- Consumes the controller's accelerate decision (accelerate_car) and stop decision (unlock_doors, renamed stop_req here), plus car_speed and a door-closed sensor.
- Produces rate-limited throttle and brake commands and a registered door-unlock.
- Doors unlock only after the car has been stationary for a hold period, never while moving.

---
 rtl/motion_sequencer_pkg.sv | 16 +
 rtl/motion_sequencer_if.sv | 24 ++
 rtl/motion_sequencer_sat_step.sv | 28 ++
 rtl/motion_sequencer.sv | 116 +++++++++++
 tb/tb_motion_sequencer.sv | 267 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/motion_sequencer_pkg.sv
// Shared constants for the motion sequencer: state encodings, command width
// and default tuning values.
package motion_pkg;
  localparam int CMD_W = 8;

  localparam int DEF_THROTTLE_STEP = 4;
  localparam int DEF_BRAKE_STEP    = 8;
  localparam int DEF_MAX_CMD       = 255;
  localparam int DEF_STOP_HOLD     = 16;

  localparam logic [2:0] ST_HOLD   = 3'd0;
  localparam logic [2:0] ST_PARK   = 3'd1;
  localparam logic [2:0] ST_ACCEL  = 3'd2;
  localparam logic [2:0] ST_DECEL  = 3'd3;
  localparam logic [2:0] ST_EBRAKE = 3'd4;
endpackage

// File: rtl/motion_sequencer_if.sv
// Controller/actuator bundle. There is no handshake: inputs are level decisions
// sampled every edge, and outputs are registered levels valid every cycle.
interface motion_sequencer_if;
  import motion_pkg::*;

  logic             accel_req;
  logic             stop_req;
  logic [CMD_W-1:0] car_speed;
  logic             door_closed;
  logic [CMD_W-1:0] throttle_cmd;
  logic [CMD_W-1:0] brake_cmd;
  logic             door_unlock;
  logic [2:0]       state;

  modport master (
    output accel_req, stop_req, car_speed, door_closed,
    input  throttle_cmd, brake_cmd, door_unlock, state
  );

  modport slave (
    input  accel_req, stop_req, car_speed, door_closed,
    output throttle_cmd, brake_cmd, door_unlock, state
  );
endinterface

// File: rtl/motion_sequencer_sat_step.sv
// 8-bit saturating up/down stepper: dir_i=1 adds step_i clamped at MAX,
// dir_i=0 subtracts step_i clamped at zero. Arithmetic is done 9 bits wide.
module sat_step
  import motion_pkg::*;
#(
  parameter int MAX = DEF_MAX_CMD
) (
  input  logic [CMD_W-1:0] value_i,
  input  logic [CMD_W-1:0] step_i,
  input  logic             dir_i,
  output logic [CMD_W-1:0] result_o
);
  logic [CMD_W:0] sum;
  logic [CMD_W:0] diff;

  assign sum  = {1'b0, value_i} + {1'b0, step_i};
  assign diff = {1'b0, value_i} - {1'b0, step_i};

  always_comb begin
    result_o = '0;
    if (dir_i) begin
      result_o = (sum > (CMD_W+1)'(MAX)) ? CMD_W'(MAX) : sum[CMD_W-1:0];
    end else begin
      // A borrow out of the top bit means the subtraction went below zero.
      result_o = diff[CMD_W] ? '0 : diff[CMD_W-1:0];
    end
  end
endmodule

// File: rtl/motion_sequencer.sv
// Actuator sequencer: turns accelerate/stop decisions into rate-limited
// throttle and brake commands, and unlocks the doors only after a stationary hold.
module motion_sequencer
  import motion_pkg::*;
#(
  parameter int THROTTLE_STEP = DEF_THROTTLE_STEP,
  parameter int BRAKE_STEP    = DEF_BRAKE_STEP,
  parameter int MAX_CMD       = DEF_MAX_CMD,
  parameter int STOP_HOLD     = DEF_STOP_HOLD
) (
  input logic               clk,
  input logic               rst,
  motion_sequencer_if.slave bus
);
  localparam int CNT_W = $clog2(STOP_HOLD + 1);

  logic [2:0]       state_q, state_d;
  logic [CNT_W-1:0] hold_cnt_q, hold_cnt_d;
  logic [CMD_W-1:0] throttle_q, throttle_d;
  logic [CMD_W-1:0] brake_q, brake_d;
  logic             unlock_q, unlock_d;
  logic [CMD_W-1:0] thr_res, brk_res;
  logic             go, speed_zero;

  assign go         = bus.accel_req && !bus.stop_req;
  assign speed_zero = (bus.car_speed == '0);

  always_comb begin
    state_d = ST_HOLD;
    case (state_q)
      ST_HOLD: begin
        if (go)                                                   state_d = ST_ACCEL;
        else if (speed_zero && hold_cnt_q == CNT_W'(STOP_HOLD-1)) state_d = ST_PARK;
        else                                                      state_d = ST_HOLD;
      end
      ST_PARK:   state_d = (go && bus.door_closed) ? ST_ACCEL : ST_PARK;
      ST_ACCEL: begin
        if (bus.stop_req)        state_d = ST_EBRAKE;
        else if (!bus.accel_req) state_d = ST_DECEL;
        else                     state_d = ST_ACCEL;
      end
      ST_DECEL: begin
        if (bus.stop_req)       state_d = ST_EBRAKE;
        else if (bus.accel_req) state_d = ST_ACCEL;
        else if (speed_zero)    state_d = ST_HOLD;
        else                    state_d = ST_DECEL;
      end
      ST_EBRAKE: state_d = speed_zero ? ST_HOLD : ST_EBRAKE;
      default:   state_d = ST_HOLD;
    endcase
  end

  assign hold_cnt_d = (state_q == ST_HOLD && speed_zero) ? hold_cnt_q + 1'b1 : '0;

  sat_step #(.MAX(MAX_CMD)) u_thr_step (
    .value_i  (throttle_q),
    .step_i   (CMD_W'(THROTTLE_STEP)),
    .dir_i    (state_d == ST_ACCEL),
    .result_o (thr_res)
  );

  sat_step #(.MAX(MAX_CMD)) u_brk_step (
    .value_i  (brake_q),
    .step_i   (CMD_W'(BRAKE_STEP)),
    .dir_i    (1'b1),
    .result_o (brk_res)
  );

  // Commands follow the state being entered, so a transition shows on the same edge.
  always_comb begin
    throttle_d = '0;
    brake_d    = CMD_W'(MAX_CMD);
    case (state_d)
      ST_ACCEL: begin
        throttle_d = thr_res;
        brake_d    = '0;
      end
      ST_DECEL: begin
        if (throttle_q != '0) begin
          throttle_d = thr_res;
          brake_d    = brake_q;
        end else begin
          throttle_d = '0;
          brake_d    = brk_res;
        end
      end
      default: begin
        throttle_d = '0;
        brake_d    = CMD_W'(MAX_CMD);
      end
    endcase
  end

  assign unlock_d = (state_d == ST_PARK);

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q    <= ST_HOLD;
      hold_cnt_q <= '0;
      throttle_q <= '0;
      brake_q    <= CMD_W'(MAX_CMD);
      unlock_q   <= 1'b0;
    end else begin
      state_q    <= state_d;
      hold_cnt_q <= hold_cnt_d;
      throttle_q <= throttle_d;
      brake_q    <= brake_d;
      unlock_q   <= unlock_d;
    end
  end

  assign bus.state        = state_q;
  assign bus.throttle_cmd = throttle_q;
  assign bus.brake_cmd    = brake_q;
  assign bus.door_unlock  = unlock_q;
endmodule

// File: tb/tb_motion_sequencer.sv
// Directed bench for motion_sequencer: one task per scenario, each with
// hand-computed expected commands and states.
module tb_motion_sequencer;
  import motion_pkg::*;

  logic clk;
  logic rst;
  int   tests_run;
  int   tests_failed;

  motion_sequencer_if bus ();

  motion_sequencer dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b0;
    bus.accel_req = 1'b1;
    bus.stop_req = 1'b0;
    bus.car_speed = 8'd50;
    bus.door_closed = 1'b1;
    step();
    step();
    tests_run++;
    if (bus.state !== ST_HOLD) begin
      tests_failed++; $display("FAIL reset_state: got %0d want %0d", bus.state, ST_HOLD);
    end
    tests_run++;
    if (bus.throttle_cmd !== 8'd0) begin
      tests_failed++; $display("FAIL reset_throttle: got %0d want 0", bus.throttle_cmd);
    end
    tests_run++;
    if (bus.brake_cmd !== 8'd255) begin
      tests_failed++; $display("FAIL reset_brake: got %0d want 255", bus.brake_cmd);
    end
    tests_run++;
    if (bus.door_unlock !== 1'b0) begin
      tests_failed++; $display("FAIL reset_unlock: got %0b want 0", bus.door_unlock);
    end
  endtask

  task automatic test_hold_to_park();
    bus.accel_req = 1'b0;
    bus.car_speed = 8'd0;
    rst = 1'b1;
    for (int k = 1; k <= 10; k++) begin
      step();
      tests_run++;
      if (bus.state !== ST_HOLD) begin
        tests_failed++; $display("FAIL hold_pre_roll edge %0d: got %0d want %0d", k, bus.state, ST_HOLD);
      end
    end
    bus.car_speed = 8'd3;
    step();
    tests_run++;
    if (bus.state !== ST_HOLD) begin
      tests_failed++; $display("FAIL hold_rolling: got %0d want %0d", bus.state, ST_HOLD);
    end
    bus.car_speed = 8'd0;
    for (int k = 1; k <= 15; k++) begin
      step();
      tests_run++;
      if (bus.state !== ST_HOLD || bus.door_unlock !== 1'b0) begin
        tests_failed++;
        $display("FAIL hold_count edge %0d: got state %0d unlock %0b want %0d/0", k, bus.state, bus.door_unlock, ST_HOLD);
      end
    end
    step();
    tests_run++;
    if (bus.state !== ST_PARK || bus.door_unlock !== 1'b1) begin
      tests_failed++;
      $display("FAIL park_entry: got state %0d unlock %0b want %0d/1", bus.state, bus.door_unlock, ST_PARK);
    end
    tests_run++;
    if (bus.throttle_cmd !== 8'd0 || bus.brake_cmd !== 8'd255) begin
      tests_failed++;
      $display("FAIL park_cmds: got thr %0d brk %0d want 0/255", bus.throttle_cmd, bus.brake_cmd);
    end
  endtask

  task automatic test_launch();
    int exp_thr;
    bus.door_closed = 1'b0;
    bus.accel_req = 1'b1;
    for (int k = 1; k <= 3; k++) begin
      step();
      tests_run++;
      if (bus.state !== ST_PARK || bus.door_unlock !== 1'b1) begin
        tests_failed++;
        $display("FAIL door_open_block edge %0d: got state %0d unlock %0b want %0d/1", k, bus.state, bus.door_unlock, ST_PARK);
      end
    end
    bus.door_closed = 1'b1;
    step();
    tests_run++;
    if (bus.state !== ST_ACCEL || bus.door_unlock !== 1'b0 || bus.brake_cmd !== 8'd0 || bus.throttle_cmd !== 8'd4) begin
      tests_failed++;
      $display("FAIL launch: got state %0d unlock %0b brk %0d thr %0d want %0d/0/0/4",
               bus.state, bus.door_unlock, bus.brake_cmd, bus.throttle_cmd, ST_ACCEL);
    end
    for (int k = 2; k <= 66; k++) begin
      step();
      exp_thr = (4 * k > 255) ? 255 : 4 * k;
      tests_run++;
      if (bus.state !== ST_ACCEL || bus.throttle_cmd !== exp_thr[7:0] || bus.brake_cmd !== 8'd0) begin
        tests_failed++;
        $display("FAIL ramp edge %0d: got state %0d thr %0d brk %0d want %0d/%0d/0",
                 k, bus.state, bus.throttle_cmd, bus.brake_cmd, ST_ACCEL, exp_thr);
      end
    end
  endtask

  task automatic test_soft_decel();
    int exp_brk;
    bus.stop_req = 1'b1;
    bus.car_speed = 8'd30;
    step();
    bus.stop_req = 1'b0;
    bus.accel_req = 1'b0;
    bus.car_speed = 8'd0;
    step();
    tests_run++;
    if (bus.state !== ST_HOLD) begin
      tests_failed++; $display("FAIL decel_setup_hold: got %0d want %0d", bus.state, ST_HOLD);
    end
    bus.accel_req = 1'b1;
    bus.car_speed = 8'd40;
    step(); step(); step();
    tests_run++;
    if (bus.throttle_cmd !== 8'd12) begin
      tests_failed++; $display("FAIL decel_setup_thr: got %0d want 12", bus.throttle_cmd);
    end
    bus.accel_req = 1'b0;
    for (int k = 1; k <= 3; k++) begin
      step();
      tests_run++;
      if (bus.state !== ST_DECEL || bus.throttle_cmd !== 8'(12 - 4 * k) || bus.brake_cmd !== 8'd0) begin
        tests_failed++;
        $display("FAIL throttle_down %0d: got state %0d thr %0d brk %0d want %0d/%0d/0",
                 k, bus.state, bus.throttle_cmd, bus.brake_cmd, ST_DECEL, 12 - 4 * k);
      end
    end
    for (int k = 1; k <= 33; k++) begin
      step();
      exp_brk = (8 * k > 255) ? 255 : 8 * k;
      tests_run++;
      if (bus.state !== ST_DECEL || bus.brake_cmd !== exp_brk[7:0] || bus.throttle_cmd !== 8'd0) begin
        tests_failed++;
        $display("FAIL brake_up %0d: got state %0d brk %0d thr %0d want %0d/%0d/0",
                 k, bus.state, bus.brake_cmd, bus.throttle_cmd, ST_DECEL, exp_brk);
      end
    end
    bus.car_speed = 8'd0;
    step();
    tests_run++;
    if (bus.state !== ST_HOLD || bus.brake_cmd !== 8'd255 || bus.throttle_cmd !== 8'd0) begin
      tests_failed++;
      $display("FAIL decel_to_hold: got state %0d brk %0d thr %0d want %0d/255/0", bus.state, bus.brake_cmd, bus.throttle_cmd, ST_HOLD);
    end
    bus.accel_req = 1'b1;
    bus.car_speed = 8'd10;
    step();
    bus.accel_req = 1'b0;
    step();
    step();
    step();
    tests_run++;
    if (bus.state !== ST_DECEL || bus.brake_cmd !== 8'd16 || bus.throttle_cmd !== 8'd0) begin
      tests_failed++;
      $display("FAIL mid_decel: got state %0d brk %0d thr %0d want %0d/16/0", bus.state, bus.brake_cmd, bus.throttle_cmd, ST_DECEL);
    end
    bus.accel_req = 1'b1;
    step();
    tests_run++;
    if (bus.state !== ST_ACCEL || bus.brake_cmd !== 8'd0 || bus.throttle_cmd !== 8'd4) begin
      tests_failed++;
      $display("FAIL decel_reaccel: got state %0d brk %0d thr %0d want %0d/0/4", bus.state, bus.brake_cmd, bus.throttle_cmd, ST_ACCEL);
    end
  endtask

  task automatic test_emergency();
    bus.car_speed = 8'd20;
    for (int k = 1; k <= 24; k++) step();
    tests_run++;
    if (bus.throttle_cmd !== 8'd100) begin
      tests_failed++; $display("FAIL ebrake_setup_thr: got %0d want 100", bus.throttle_cmd);
    end
    bus.stop_req = 1'b1;
    step();
    tests_run++;
    if (bus.state !== ST_EBRAKE || bus.throttle_cmd !== 8'd0 || bus.brake_cmd !== 8'd255) begin
      tests_failed++;
      $display("FAIL ebrake_entry: got state %0d thr %0d brk %0d want %0d/0/255", bus.state, bus.throttle_cmd, bus.brake_cmd, ST_EBRAKE);
    end
    bus.stop_req = 1'b0;
    bus.accel_req = 1'b1;
    for (int k = 1; k <= 3; k++) begin
      step();
      tests_run++;
      if (bus.state !== ST_EBRAKE || bus.throttle_cmd !== 8'd0 || bus.brake_cmd !== 8'd255) begin
        tests_failed++;
        $display("FAIL ebrake_hold %0d: got state %0d thr %0d brk %0d want %0d/0/255", k, bus.state, bus.throttle_cmd, bus.brake_cmd, ST_EBRAKE);
      end
    end
    bus.car_speed = 8'd0;
    step();
    tests_run++;
    if (bus.state !== ST_HOLD || bus.brake_cmd !== 8'd255) begin
      tests_failed++;
      $display("FAIL ebrake_exit: got state %0d brk %0d want %0d/255", bus.state, bus.brake_cmd, ST_HOLD);
    end
  endtask

  task automatic test_conflicts();
    bus.accel_req = 1'b1;
    bus.stop_req = 1'b1;
    for (int k = 1; k <= 3; k++) begin
      step();
      tests_run++;
      if (bus.state !== ST_HOLD || bus.throttle_cmd !== 8'd0) begin
        tests_failed++;
        $display("FAIL conflict_hold %0d: got state %0d thr %0d want %0d/0", k, bus.state, bus.throttle_cmd, ST_HOLD);
      end
    end
    bus.stop_req = 1'b0;
    bus.car_speed = 8'd15;
    for (int k = 1; k <= 15; k++) step();
    tests_run++;
    if (bus.state !== ST_ACCEL || bus.throttle_cmd !== 8'd60) begin
      tests_failed++;
      $display("FAIL reset_setup: got state %0d thr %0d want %0d/60", bus.state, bus.throttle_cmd, ST_ACCEL);
    end
    rst = 1'b0;
    step();
    tests_run++;
    if (bus.state !== ST_HOLD || bus.throttle_cmd !== 8'd0 || bus.brake_cmd !== 8'd255 || bus.door_unlock !== 1'b0) begin
      tests_failed++;
      $display("FAIL midramp_reset: got state %0d thr %0d brk %0d unlock %0b want %0d/0/255/0",
               bus.state, bus.throttle_cmd, bus.brake_cmd, bus.door_unlock, ST_HOLD);
    end
    rst = 1'b1;
  endtask

  initial begin
    tests_run = 0;
    tests_failed = 0;
    test_reset();
    test_hold_to_park();
    test_launch();
    test_soft_decel();
    test_emergency();
    test_conflicts();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end
endmodule
